// File: rtl/pipe_latch_skid.sv
// pipe_latch_skid: one-entry pipeline latch with optional skid register.
// Define PIPE_LATCH_SKID_EN to add the skid entry and register in_ready.
// Without it, the block is a single register and in_ready is combinational.
// flush discards every held entry. An input offered during a flush is dropped.
// out_data/out_pc always show the main register.

module pipe_latch_skid #(
    parameter int unsigned DATA_W        = 64,
    parameter int unsigned PC_W          = 32,
    parameter bit          FLUSH_KEEP_PC = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [PC_W-1:0]   in_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [PC_W-1:0]   out_pc,
    output logic [1:0]        occ
);

    // The state encoding equals the number of held entries.
`ifdef PIPE_LATCH_SKID_EN
    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StFull  = 2'd1,
        StSkid  = 2'd2
    } state_e;
`else
    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StFull  = 2'd1
    } state_e;
`endif

    state_e            state_q, state_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [PC_W-1:0]   main_pc_q, main_pc_d;
    logic              in_xfer;
    logic              out_xfer;
    logic [PC_W-1:0]   flush_pc;

    // A flush blocks both handshakes, even when the valid/ready pairs are high.
    assign in_xfer   = in_valid & in_ready & ~flush;
    assign out_xfer  = out_valid & out_ready & ~flush;
    assign flush_pc  = FLUSH_KEEP_PC ? in_pc : '0;

    assign out_valid = (state_q != StEmpty);
    assign out_data  = main_data_q;
    assign out_pc    = main_pc_q;
    assign occ       = state_q;

`ifdef PIPE_LATCH_SKID_EN

    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic [PC_W-1:0]   skid_pc_q, skid_pc_d;
    logic              in_ready_q, in_ready_d;

    assign in_ready = in_ready_q;

    // Next-state logic. The main register is the head; the skid register holds the second entry.
    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_pc_d   = main_pc_q;
        skid_data_d = skid_data_q;
        skid_pc_d   = skid_pc_q;
        if (flush) begin
            state_d     = StEmpty;
            main_data_d = '0;
            main_pc_d   = flush_pc;
            skid_data_d = '0;
            skid_pc_d   = '0;
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (in_xfer) begin
                        state_d     = StFull;
                        main_data_d = in_data;
                        main_pc_d   = in_pc;
                    end
                end
                StFull: begin
                    if (in_xfer && out_xfer) begin
                        main_data_d = in_data;
                        main_pc_d   = in_pc;
                    end else if (out_xfer) begin
                        state_d = StEmpty;
                    end else if (in_xfer) begin
                        state_d     = StSkid;
                        skid_data_d = in_data;
                        skid_pc_d   = in_pc;
                    end
                end
                StSkid: begin
                    // in_ready is low here, so only the head can leave.
                    if (out_xfer) begin
                        state_d     = StFull;
                        main_data_d = skid_data_q;
                        main_pc_d   = skid_pc_q;
                        skid_data_d = '0;
                        skid_pc_d   = '0;
                    end
                end
                default: state_d = StEmpty;
            endcase
        end
        // Registering in_ready from state_d keeps out_ready off the in_ready path.
        in_ready_d = (state_d != StSkid);
    end

    // Skid entry and registered in_ready. Reset sets in_ready so the first edge can accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_data_q <= '0;
            skid_pc_q   <= '0;
            in_ready_q  <= 1'b1;
        end else begin
            skid_data_q <= skid_data_d;
            skid_pc_q   <= skid_pc_d;
            in_ready_q  <= in_ready_d;
        end
    end

`else

    // Single-entry build: a new entry is taken when the head is empty or is leaving.
    assign in_ready = ~out_valid | out_ready;

    // Next-state logic. In StFull an input transfer always comes with an output transfer.
    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_pc_d   = main_pc_q;
        if (flush) begin
            state_d     = StEmpty;
            main_data_d = '0;
            main_pc_d   = flush_pc;
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (in_xfer) begin
                        state_d     = StFull;
                        main_data_d = in_data;
                        main_pc_d   = in_pc;
                    end
                end
                StFull: begin
                    if (in_xfer) begin
                        main_data_d = in_data;
                        main_pc_d   = in_pc;
                    end else if (out_xfer) begin
                        state_d = StEmpty;
                    end
                end
                default: state_d = StEmpty;
            endcase
        end
    end

`endif

    // State and head entry. The reset is asynchronous, so entries are discarded without a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StEmpty;
            main_data_q <= '0;
            main_pc_q   <= '0;
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            main_pc_q   <= main_pc_d;
        end
    end

    // Invariants on the held-entry count and the handshake.
`ifdef PIPE_LATCH_SKID_EN
    assert property (@(posedge clk) disable iff (!rst_n) occ != 2'd3);
    assert property (@(posedge clk) disable iff (!rst_n) (occ == 2'd2) |-> !in_ready);
`else
    assert property (@(posedge clk) disable iff (!rst_n) occ <= 2'd1);
`endif

endmodule

// File: tb/tb_pipe_latch_skid.sv
// Self-checking bench for pipe_latch_skid.
// A negedge monitor keeps a reference model of the occupancy and a scoreboard of accepted
// entries. Each scenario task makes its own checks at specific points.

module tb_pipe_latch_skid;

    localparam int DataW  = 64;
    localparam int PcW    = 32;
    localparam bit KeepPc = 1'b1;
`ifdef PIPE_LATCH_SKID_EN
    localparam int MaxOcc = 2;
`else
    localparam int MaxOcc = 1;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [DataW-1:0] in_data = '0;
    logic [PcW-1:0]   in_pc = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [DataW-1:0] out_data;
    logic [PcW-1:0]   out_pc;
    logic [1:0]       occ;

    int tests_run = 0;
    int failures  = 0;
    int out_count = 0;
    int m_occ     = 0;
    logic                 m_rdy;
    logic [DataW+PcW-1:0] m_head;
    logic [DataW+PcW-1:0] exp_q[$];

    pipe_latch_skid #(
        .DATA_W       (DataW),
        .PC_W         (PcW),
        .FLUSH_KEEP_PC(KeepPc)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_pc    (in_pc),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_pc   (out_pc),
        .occ      (occ)
    );

    always #5 clk = ~clk;

    // Reference model and scoreboard. Inputs are stable at negedge, so the transfers at the next
    // posedge can be predicted here.
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            exp_q.delete();
            m_occ = 0;
        end else begin
`ifdef PIPE_LATCH_SKID_EN
            m_rdy = (m_occ != MaxOcc);
`else
            m_rdy = (m_occ == 0) || out_ready;
`endif
            tests_run++;
            if (out_valid !== (m_occ != 0)) begin
                failures++;
                $display("FAIL mon_out_valid: got %b want %b", out_valid, (m_occ != 0));
            end
            tests_run++;
            if (occ !== 2'(m_occ)) begin
                failures++;
                $display("FAIL mon_occ: got %0d want %0d", occ, m_occ);
            end
            tests_run++;
            if (in_ready !== m_rdy) begin
                failures++;
                $display("FAIL mon_in_ready: got %b want %b", in_ready, m_rdy);
            end
            if (flush) begin
                exp_q.delete();
                m_occ = 0;
            end else begin
                if ((m_occ != 0) && out_ready) begin
                    tests_run++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL sb_underflow: got output %h, want no output", out_data);
                    end else begin
                        m_head = exp_q.pop_front();
                        if ({out_data, out_pc} !== m_head) begin
                            failures++;
                            $display("FAIL sb_order: got data %h pc %h want data %h pc %h",
                                     out_data, out_pc, m_head[DataW+PcW-1:PcW], m_head[PcW-1:0]);
                        end
                    end
                    m_occ--;
                    out_count++;
                end
                if (in_valid && m_rdy) begin
                    exp_q.push_back({in_data, in_pc});
                    m_occ++;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if (out_valid !== 1'b0 || occ !== 2'd0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ctrl: got valid %b occ %0d rdy %b want 0 0 1",
                     out_valid, occ, in_ready);
        end
        tests_run++;
        if (out_data !== '0 || out_pc !== '0) begin
            failures++;
            $display("FAIL reset_data: got %h/%h want 0/0", out_data, out_pc);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        in_valid = 1'b1;
        in_data  = 64'hA5;
        in_pc    = 32'h100;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== 64'hA5 || out_pc !== 32'h100 || occ !== 2'd1) begin
            failures++;
            $display("FAIL basic: got v%b d%h pc%h occ%0d want v1 d a5 pc 100 occ1",
                     out_valid, out_data, out_pc, occ);
        end
        step();
    endtask

    task automatic test_skid();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 64'h1;
        in_pc     = 32'h10;
        step();
`ifdef PIPE_LATCH_SKID_EN
        in_data = 64'h2;
        in_pc   = 32'h14;
        step();
        in_valid = 1'b0;
        tests_run++;
        if (occ !== 2'd2 || in_ready !== 1'b0 || out_data !== 64'h1) begin
            failures++;
            $display("FAIL skid_full: got occ%0d rdy%b d%h want occ2 rdy0 d1",
                     occ, in_ready, out_data);
        end
        out_ready = 1'b1;
        step();
        tests_run++;
        if (out_data !== 64'h2 || out_pc !== 32'h14 || occ !== 2'd1) begin
            failures++;
            $display("FAIL skid_drain: got d%h pc%h occ%0d want d2 pc14 occ1",
                     out_data, out_pc, occ);
        end
        step();
`else
        in_valid = 1'b0;
        tests_run++;
        if (occ !== 2'd1 || in_ready !== 1'b0 || out_data !== 64'h1) begin
            failures++;
            $display("FAIL stall: got occ%0d rdy%b d%h want occ1 rdy0 d1", occ, in_ready, out_data);
        end
        out_ready = 1'b1;
        #1;
        tests_run++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL comb_ready: got %b want 1", in_ready);
        end
        step();
`endif
        tests_run++;
        if (occ !== 2'd0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL drain_empty: got occ%0d v%b want 0 0", occ, out_valid);
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        for (int i = 0; i < MaxOcc; i++) begin
            in_valid = 1'b1;
            in_data  = 64'h30 + 64'(i);
            in_pc    = 32'h30 + 32'(i);
            step();
        end
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 64'hDEAD;
        in_pc    = 32'h200;
        step();
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tests_run++;
        if (occ !== 2'd0 || out_valid !== 1'b0 || out_data !== '0) begin
            failures++;
            $display("FAIL flush_state: got occ%0d v%b d%h want 0 0 0", occ, out_valid, out_data);
        end
        tests_run++;
        if (out_pc !== (KeepPc ? 32'h200 : 32'h0)) begin
            failures++;
            $display("FAIL flush_pc: got %h want %h", out_pc, (KeepPc ? 32'h200 : 32'h0));
        end
        step();
        tests_run++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL flush_drop: got v%b want 0", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        int base;
        base      = out_count;
        out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            in_valid = 1'b1;
            in_data  = 64'd1000 + 64'(i);
            in_pc    = 32'h1000 + 32'(4 * i);
            step();
            tests_run++;
            if (occ !== 2'd1 || out_data !== 64'd1000 + 64'(i)) begin
                failures++;
                $display("FAIL b2b_%0d: got occ%0d d%0d want occ1 d%0d",
                         i, occ, out_data, 1000 + i);
            end
        end
        in_valid = 1'b0;
        step();
        tests_run++;
        if (out_count - base != 100) begin
            failures++;
            $display("FAIL b2b_count: got %0d outputs want 100", out_count - base);
        end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        for (int i = 0; i < MaxOcc; i++) begin
            in_valid = 1'b1;
            in_data  = 64'h50 + 64'(i);
            in_pc    = 32'h50;
            step();
        end
        in_valid = 1'b0;
        tests_run++;
        if (occ !== 2'(MaxOcc)) begin
            failures++;
            $display("FAIL areset_fill: got occ%0d want %0d", occ, MaxOcc);
        end
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (out_valid !== 1'b0 || occ !== 2'd0 || in_ready !== 1'b1 || out_data !== '0) begin
            failures++;
            $display("FAIL areset_mid: got v%b occ%0d rdy%b d%h want 0 0 1 0",
                     out_valid, occ, in_ready, out_data);
        end
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        in_valid  = 1'b1;
        in_data   = 64'h77;
        in_pc     = 32'h300;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== 64'h77) begin
            failures++;
            $display("FAIL first_after_reset: got v%b d%h want 1 77", out_valid, out_data);
        end
        step();
    endtask

    task automatic test_random();
        for (int i = 0; i < 10000; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            in_data   = {$urandom, $urandom};
            in_pc     = $urandom;
            step();
            if (occ > 2'(MaxOcc)) begin
                tests_run++;
                failures++;
                $display("FAIL rand_occ_%0d: got %0d want <= %0d", i, occ, MaxOcc);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (MaxOcc + 2) step();
        tests_run++;
        if (occ !== 2'd0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL rand_drain: got occ%0d v%b want 0 0", occ, out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_skid();
        test_flush();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule

// File: doc/pipe_latch_skid.md
PIPE_LATCH_SKID -- requirements
Module: pipe_latch_skid

Interface
REQ-001 The block SHALL have parameter DATA_W, default 64: width of the payload (decoded fields, immediate, flags).
REQ-002 The block SHALL have parameter PC_W, default 32: width of the carried program counter.
REQ-003 The block SHALL have parameter FLUSH_KEEP_PC, default 1: when 1, flush loads out_pc from in_pc; when 0, flush clears out_pc to 0.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset, with ports as follows.
- clk  input  1: rising-edge clock.
- rst_n  input  1: asynchronous, active-low reset.
REQ-005 The block SHALL have the following remaining ports.
- flush  input  1: synchronous discard of all held entries.
- in_valid  input  1: upstream offers an entry.
- in_ready  output  1: block accepts an entry.
- in_data  input  DATA_W: upstream payload.
- in_pc  input  PC_W: upstream PC.
- out_valid  output  1: downstream entry valid.
- out_ready  input  1: downstream consumes.
- out_data  output  DATA_W: head payload.
- out_pc  output  PC_W: head PC.
- occ  output  2: entries held (0, 1 or 2).

Function
REQ-006 An input transfer SHALL occur on a rising edge where in_valid=1, in_ready=1 and flush=0; an output transfer SHALL occur where out_valid=1, out_ready=1 and flush=0.
REQ-007 The state machine SHALL have the states EMPTY (occ=0), FULL (occ=1, main register valid) and SKID (occ=2, main and skid registers valid).
REQ-008 From EMPTY, an input transfer SHALL move to FULL, with main loaded from in_*; latency from input to out_valid is 1 cycle.
REQ-009 In FULL with both transfers, main SHALL reload from in_* and the state SHALL stay FULL; with output only, it SHALL go to EMPTY; with input only, it SHALL go to SKID with skid loaded from in_*.
REQ-010 In SKID, in_ready SHALL be 0; an output transfer SHALL move skid into main and go to FULL.
REQ-011 out_data/out_pc SHALL always show main; they SHALL hold their value while out_valid=1 and out_ready=0.
REQ-012 Entries SHALL leave in arrival order; no entry SHALL be lost or duplicated.
REQ-013 flush=1 at an edge SHALL take priority over all transfers: next state EMPTY, occ=0, out_valid=0, out_data=0, skid cleared.
REQ-014 On flush, out_pc SHALL load in_pc when FLUSH_KEEP_PC=1, else 0.
REQ-015 Any input offered in a flush cycle SHALL be dropped.
REQ-016 occ SHALL be registered and equal the state encoding.

Reset
REQ-017 While rst_n=0, the block SHALL asynchronously force: state EMPTY, occ=0, out_valid=0, out_data=0, out_pc=0, skid register=0, in_ready=1.
REQ-018 Reset asserted mid-operation SHALL discard all entries immediately, without waiting for a clock edge.
REQ-019 The first transfer SHALL be accepted on the first rising edge after rst_n rises.

Configuration
REQ-020 With macro PIPE_LATCH_SKID_EN defined, in_ready SHALL be a register, set exactly when next state is not SKID, so there is no combinational path from out_ready to in_ready.
REQ-021 Without PIPE_LATCH_SKID_EN, the skid register and SKID state SHALL be absent, occ SHALL never exceed 1, and in_ready SHALL be !out_valid | out_ready (combinational).
REQ-022 All other requirements SHALL hold in both builds.

Verification
REQ-023 The bench SHALL cover: reset, then in_valid=1, in_data=0xA5, in_pc=0x100, out_ready=1 -> next cycle out_valid=1, out_data=0xA5, out_pc=0x100, occ=1.
REQ-024 The bench SHALL cover (SKID_EN): out_ready=0, push 0x1 then 0x2 -> occ=2, in_ready=0; raise out_ready -> 0x1 then 0x2 on consecutive cycles, then occ=0.
REQ-025 The bench SHALL cover: occ=2, flush=1 with in_valid=1, in_pc=0x200 -> next cycle occ=0, out_valid=0, out_data=0, out_pc=0x200 (FLUSH_KEEP_PC=1) or 0 (=0); offered entry absent.
REQ-026 The bench SHALL cover: continuous in_valid=1 and out_ready=1 for 100 cycles with an incrementing payload -> one output per cycle, in order, occ constant at 1.
REQ-027 The bench SHALL cover: rst_n pulled low between edges while occ=2 -> out_valid=0, occ=0, in_ready=1 before the next edge.
REQ-028 The bench SHALL cover: random in_valid/out_ready at 50% for 10000 cycles in both builds -> output sequence equals input sequence, occ never exceeds 2 (SKID_EN) or 1 (no SKID_EN).
